// File: rtl/game_pkg.sv
// Shared constants and FSM state encoding for the brick breaker game controller.
package game_pkg;

    localparam logic [2:0] ATTRACT   = 3'd0;
    localparam logic [2:0] SERVE     = 3'd1;
    localparam logic [2:0] PLAY      = 3'd2;
    localparam logic [2:0] MISS      = 3'd3;
    localparam logic [2:0] GAME_OVER = 3'd4;
    localparam logic [2:0] WIN       = 3'd5;

    typedef enum logic [2:0] {
        StAttract  = ATTRACT,
        StServe    = SERVE,
        StPlay     = PLAY,
        StMiss     = MISS,
        StGameOver = GAME_OVER,
        StWin      = WIN
    } state_e;

    localparam int unsigned LIVES_INIT_DEF   = 3;
    localparam int unsigned BRICK_COUNT_DEF  = 40;
    localparam int unsigned BRICK_POINTS_DEF = 10;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    localparam int unsigned SCORE_W = 16;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle movement tick every TICK_DIV clocks.
module tick_gen #(
    parameter int unsigned TICK_DIV = 208333
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == CntMax);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = w_wrap;

endmodule

// File: rtl/game_ctrl.sv
// Brick breaker game sequencer: start key conditioning, serve/play/miss FSM, lives/score/bricks.
// Optional: define GAME_CTRL_BONUS_LIFE_EN to award a life for every 500 points crossed.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 208333,
    parameter int unsigned SERVE_TICKS  = 120,
    parameter int unsigned MISS_TICKS   = 240,
    parameter int unsigned LIVES_INIT   = LIVES_INIT_DEF,
    parameter int unsigned BRICK_COUNT  = BRICK_COUNT_DEF,
    parameter int unsigned BRICK_POINTS = BRICK_POINTS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start_n,
    input  logic               i_ball_lost,
    input  logic               i_brick_hit,
    output logic               o_tick,
    output logic               o_paddle_en,
    output logic               o_ball_hold,
    output logic               o_ball_launch,
    output logic [2:0]         o_lives,
    output logic [SCORE_W-1:0] o_score,
    output logic [7:0]         o_bricks_left,
    output logic [2:0]         o_state
);

    state_e             r_state, w_state_nxt;
    logic [7:0]         r_phase, w_phase_nxt;
    logic [2:0]         r_lives, w_lives_nxt;
    logic [SCORE_W-1:0] r_score, w_score_nxt;
    logic [7:0]         r_bricks, w_bricks_nxt;
    logic               r_launch, w_launch_nxt;
    logic [1:0]         r_sync;
    logic               r_sync_prev;
    logic               r_start_pulse;
    logic               w_tick;
    logic [SCORE_W:0]   w_score_sum;
    logic [SCORE_W-1:0] w_score_sat;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .o_tick(w_tick)
    );

    // Synchronizer resets to the released level so reset never fakes a key press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync        <= 2'b11;
            r_sync_prev   <= 1'b1;
            r_start_pulse <= 1'b0;
        end else begin
            r_sync        <= {r_sync[0], i_start_n};
            r_sync_prev   <= r_sync[1];
            r_start_pulse <= r_sync_prev & ~r_sync[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StAttract;
            r_phase  <= '0;
            r_lives  <= 3'(LIVES_INIT);
            r_score  <= '0;
            r_bricks <= 8'(BRICK_COUNT);
            r_launch <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_lives  <= w_lives_nxt;
            r_score  <= w_score_nxt;
            r_bricks <= w_bricks_nxt;
            r_launch <= w_launch_nxt;
        end
    end

    assign w_score_sum = {1'b0, r_score} + (SCORE_W + 1)'(BRICK_POINTS);
    assign w_score_sat = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_lives_nxt  = r_lives;
        w_score_nxt  = r_score;
        w_bricks_nxt = r_bricks;
        w_launch_nxt = 1'b0;
        case (r_state)
            StAttract: begin
                if (r_start_pulse) begin
                    w_lives_nxt  = 3'(LIVES_INIT);
                    w_score_nxt  = '0;
                    w_bricks_nxt = 8'(BRICK_COUNT);
                    w_state_nxt  = StServe;
                end
            end
            StServe: begin
                if (r_start_pulse || (r_phase == 8'(SERVE_TICKS))) begin
                    w_launch_nxt = 1'b1;
                    w_state_nxt  = StPlay;
                end
            end
            StPlay: begin
                if (i_brick_hit && (r_bricks != 8'd0)) begin
                    w_bricks_nxt = r_bricks - 8'd1;
                    w_score_nxt  = w_score_sat;
`ifdef GAME_CTRL_BONUS_LIFE_EN
                    if (((w_score_sat / 16'd500) != (r_score / 16'd500)) && (r_lives != 3'd7)) begin
                        w_lives_nxt = r_lives + 3'd1;
                    end
`endif
                end
                // A clearing hit wins over a simultaneous loss.
                if (i_brick_hit && (r_bricks == 8'd1)) begin
                    w_state_nxt = StWin;
                end else if (i_ball_lost) begin
                    w_lives_nxt = w_lives_nxt - 3'd1;
                    w_state_nxt = (r_lives == 3'd1) ? StGameOver : StMiss;
                end
            end
            StMiss: begin
                if (r_phase == 8'(MISS_TICKS)) begin
                    w_state_nxt = StServe;
                end
            end
            StGameOver, StWin: begin
                if (r_start_pulse) begin
                    w_state_nxt = StAttract;
                end
            end
            default: w_state_nxt = StAttract;
        endcase

        if (w_state_nxt != r_state) begin
            w_phase_nxt = '0;
        end else if (w_tick && ((r_state == StServe) || (r_state == StMiss))) begin
            w_phase_nxt = r_phase + 8'd1;
        end else begin
            w_phase_nxt = r_phase;
        end
    end

    always_comb begin
        o_paddle_en = 1'b0;
        o_ball_hold = 1'b1;
        case (r_state)
            StServe: o_paddle_en = 1'b1;
            StPlay: begin
                o_paddle_en = 1'b1;
                o_ball_hold = 1'b0;
            end
            default: ;
        endcase
    end

    assign o_tick        = w_tick;
    assign o_ball_launch = r_launch;
    assign o_lives       = r_lives;
    assign o_score       = r_score;
    assign o_bricks_left = r_bricks;
    assign o_state       = r_state;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench: three game_ctrl instances (default, one brick, one life) with a fast tick.
module tb_game_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] start_n;
    logic [2:0] hit;
    logic [2:0] lost;

    logic       tick   [3];
    logic       pen    [3];
    logic       hold   [3];
    logic       launch [3];
    logic [2:0] lives  [3];
    logic [15:0] score [3];
    logic [7:0] bricks [3];
    logic [2:0] st     [3];

    int n_chk = 0;
    int n_err = 0;

    game_ctrl #(.TICK_DIV(4)) u_dut_a (
        .clk(clk), .rst(rst), .i_start_n(start_n[0]), .i_ball_lost(lost[0]),
        .i_brick_hit(hit[0]), .o_tick(tick[0]), .o_paddle_en(pen[0]), .o_ball_hold(hold[0]),
        .o_ball_launch(launch[0]), .o_lives(lives[0]), .o_score(score[0]),
        .o_bricks_left(bricks[0]), .o_state(st[0])
    );

    game_ctrl #(.TICK_DIV(4), .BRICK_COUNT(1)) u_dut_b (
        .clk(clk), .rst(rst), .i_start_n(start_n[1]), .i_ball_lost(lost[1]),
        .i_brick_hit(hit[1]), .o_tick(tick[1]), .o_paddle_en(pen[1]), .o_ball_hold(hold[1]),
        .o_ball_launch(launch[1]), .o_lives(lives[1]), .o_score(score[1]),
        .o_bricks_left(bricks[1]), .o_state(st[1])
    );

    game_ctrl #(.TICK_DIV(4), .LIVES_INIT(1)) u_dut_c (
        .clk(clk), .rst(rst), .i_start_n(start_n[2]), .i_ball_lost(lost[2]),
        .i_brick_hit(hit[2]), .o_tick(tick[2]), .o_paddle_en(pen[2]), .o_ball_hold(hold[2]),
        .o_ball_launch(launch[2]), .o_lives(lives[2]), .o_score(score[2]),
        .o_bricks_left(bricks[2]), .o_state(st[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Key pressed for two cycles; three more cycles let the pulse reach the FSM.
    task automatic key(input int d);
        start_n[d] = 1'b0;
        repeat (2) @(negedge clk);
        start_n[d] = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse(input int d, input logic h, input logic l);
        hit[d]  = h;
        lost[d] = l;
        @(negedge clk);
        hit[d]  = 1'b0;
        lost[d] = 1'b0;
    endtask

    task automatic wait_st(input int d, input logic [2:0] s, input int max_cyc);
        int n;
        n = 0;
        while (st[d] !== s && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        time t0;
        int  tc;
        int  nl;
        int  cyc;

        rst     = 1'b0;
        start_n = 3'b111;
        hit     = 3'b000;
        lost    = 3'b000;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_state", st[0], 0);
        chk("rst_tick", tick[0], 0);
        chk("rst_paddle_en", pen[0], 0);
        chk("rst_ball_hold", hold[0], 1);
        chk("rst_launch", launch[0], 0);
        chk("rst_lives", lives[0], 3);
        chk("rst_score", score[0], 0);
        chk("rst_bricks", bricks[0], 40);

        rst = 1'b1;
        tc = 0;
        repeat (16) begin
            @(negedge clk);
            tc += int'(tick[0]);
        end
        chk("tick_count_16cyc", tc, 4);

        // Start key held for 10 cycles: Serve on the 4th sample, no second pulse
        start_n[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_lat3_attract", st[0], 0);
        @(negedge clk);
        chk("start_lat4_serve", st[0], 1);
        t0 = $time;
        repeat (6) @(negedge clk);
        start_n[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("key_hold_one_pulse", st[0], 1);
        chk("serve_lives", lives[0], 3);
        chk("serve_score", score[0], 0);
        chk("serve_bricks", bricks[0], 40);
        chk("serve_paddle_en", pen[0], 1);
        chk("serve_hold", hold[0], 1);

        // Auto-launch after 120 ticks
        nl = 0;
        cyc = 0;
        while (st[0] !== 3'd2 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            nl += int'(launch[0]);
        end
        chk("play_reached", st[0], 2);
        cyc = int'(($time - t0) / 10);
        chk("serve_len_in_range", (cyc >= 476 && cyc <= 483), 1);
        chk("launch_with_play", launch[0], 1);
        chk("launch_count", nl, 1);
        chk("play_hold", hold[0], 0);
        chk("play_paddle_en", pen[0], 1);
        @(negedge clk);
        chk("launch_one_cycle", launch[0], 0);

        // Three hits, then a loss
        repeat (3) begin
            pulse(0, 1'b1, 1'b0);
            @(negedge clk);
        end
        chk("hits3_score", score[0], 30);
        chk("hits3_bricks", bricks[0], 37);
        pulse(0, 1'b0, 1'b1);
        t0 = $time;
        chk("lost_lives", lives[0], 2);
        chk("lost_state_miss", st[0], 3);
        chk("miss_paddle_en", pen[0], 0);
        chk("miss_hold", hold[0], 1);
        pulse(0, 1'b1, 1'b0);
        chk("miss_hit_ignored", score[0], 30);
        wait_st(0, 3'd1, 1200);
        chk("miss_to_serve", st[0], 1);
        cyc = int'(($time - t0) / 10);
        chk("miss_len_in_range", (cyc >= 956 && cyc <= 963), 1);

        // Key launches from Serve, then reach score 120
        key(0);
        chk("key_launch_play", st[0], 2);
        repeat (9) pulse(0, 1'b1, 1'b0);
        chk("score_120", score[0], 120);
        chk("bricks_28", bricks[0], 28);

        // Single-brick instance: hit and loss together -> Win
        key(1);
        chk("b_serve", st[1], 1);
        key(1);
        chk("b_play", st[1], 2);
        pulse(1, 1'b1, 1'b1);
        chk("b_win_state", st[1], 5);
        chk("b_win_lives", lives[1], 3);
        chk("b_win_score", score[1], 10);
        chk("b_win_bricks", bricks[1], 0);
        pulse(1, 1'b1, 1'b0);
        chk("b_win_hit_ignored", score[1], 10);
        key(1);
        chk("b_attract", st[1], 0);
        chk("b_attract_frozen_score", score[1], 10);
        chk("b_attract_frozen_bricks", bricks[1], 0);
        key(1);
        chk("b_reload_bricks", bricks[1], 1);
        chk("b_reload_score", score[1], 0);

        // One-life instance: loss -> GameOver
        key(2);
        key(2);
        chk("c_play", st[2], 2);
        pulse(2, 1'b0, 1'b1);
        chk("c_game_over", st[2], 4);
        chk("c_go_lives", lives[2], 0);
        chk("c_go_bricks", bricks[2], 40);
        pulse(2, 1'b1, 1'b0);
        chk("c_go_hit_ignored", bricks[2], 40);
        key(2);
        chk("c_attract", st[2], 0);
        chk("c_attract_lives_frozen", lives[2], 0);
        key(2);
        chk("c_reload_state", st[2], 1);
        chk("c_reload_lives", lives[2], 1);
        chk("c_reload_bricks", bricks[2], 40);

        // Asynchronous reset mid-play, between clock edges
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_state", st[0], 0);
        chk("arst_score", score[0], 0);
        chk("arst_lives", lives[0], 3);
        chk("arst_bricks", bricks[0], 40);
        chk("arst_hold", hold[0], 1);
        chk("arst_paddle_en", pen[0], 0);
        chk("arst_launch", launch[0], 0);
        chk("arst_tick", tick[0], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
